// File: rtl/cpu_regs_pkg.sv
// cpu_regs_pkg: register file widths, special register numbers and the write-queue entry type
package cpu_regs_pkg;
    localparam int REG_AW = 4;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_PC = 4'hF;
    localparam logic [REG_AW-1:0] REG_LR = 4'hE;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wbq_entry_t;
endpackage

// File: rtl/wbq_match.sv
// wbq_match: one read-select compare over age-ordered queue entries (index 0 oldest); youngest-data
// forwarding is built only with REG_WBQ_FWD_EN
module wbq_match
    import cpu_regs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic [DEPTH-1:0]         vld,
    input  logic [DEPTH-1:0][AW-1:0] rd,
    input  logic [DEPTH-1:0][DW-1:0] data,
    input  logic [AW-1:0]            sel,
    output logic                     hit,
    output logic [DW-1:0]            fwd
);
    logic [DEPTH-1:0] m;
    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            m[k] = vld[k] && rd[k] == sel && sel != AW'(REG_PC);
    end
    assign hit = |m;
`ifdef REG_WBQ_FWD_EN
    // later (younger) matches override earlier ones
    always_comb begin
        fwd = '0;
        for (int k = 0; k < DEPTH; k++)
            if (m[k]) fwd = data[k];
    end
`else
    logic unused_data;
    assign unused_data = ^data;
    assign fwd = '0;
`endif
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: FIFO of register writes drained onto the regfile port, with pending-write hits
// for three read selects; define REG_WBQ_FWD_EN to also return the youngest queued data per select
module reg_writeback_queue
    import cpu_regs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic                     clock,
    input  logic                     R,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rd,
    input  logic [DW-1:0]            in_data,
    input  logic                     wr_hold,
    input  logic                     flush,
    output logic                     Ld,
    output logic [AW-1:0]            decode_input,
    output logic [DW-1:0]            Ds,
    input  logic [AW-1:0]            S1,
    input  logic [AW-1:0]            S2,
    input  logic [AW-1:0]            S3,
    output logic                     hit1,
    output logic                     hit2,
    output logic                     hit3,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [DW-1:0]            fwd3,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_r15
);
    localparam int PW = $clog2(DEPTH);
    wbq_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic push;
    logic [DEPTH-1:0] age_vld;
    logic [DEPTH-1:0][AW-1:0] age_rd;
    logic [DEPTH-1:0][DW-1:0] age_data;
    logic [2:0][AW-1:0] sel;
    logic [2:0] hit;
    logic [2:0][DW-1:0] fwd;
    assign in_ready = count != (PW+1)'(DEPTH);
    assign Ld = count != '0 && !wr_hold && !flush;
    assign push = in_valid && in_ready && !flush && in_rd != AW'(REG_PC);
    assign decode_input = mem[rd_ptr].rd;
    assign Ds = mem[rd_ptr].data;
    always_ff @(posedge clock or negedge R) begin
        if (!R) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            err_r15 <= 1'b0;
        end else begin
            if (in_valid && in_ready && in_rd == AW'(REG_PC)) err_r15 <= 1'b1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (Ld) rd_ptr <= rd_ptr + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(Ld);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{rd: in_rd, data: in_data};
    end
    // entries re-ordered oldest-first so the match logic can resolve age without pointers
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_vld[k] = (PW+1)'(k) < count;
            age_rd[k] = mem[rd_ptr + PW'(k)].rd;
            age_data[k] = mem[rd_ptr + PW'(k)].data;
        end
    end
    assign sel = {S3, S2, S1};
    for (genvar g = 0; g < 3; g++) begin : g_match
        wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match (
            .vld(age_vld),
            .rd(age_rd),
            .data(age_data),
            .sel(sel[g]),
            .hit(hit[g]),
            .fwd(fwd[g])
        );
    end
    assign {hit3, hit2, hit1} = hit;
    assign fwd1 = fwd[0];
    assign fwd2 = fwd[1];
    assign fwd3 = fwd[2];
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed stimulus with a write-port scoreboard popped by a monitor on Ld
module tb_reg_writeback_queue;
    logic clock = 1'b0;
    logic R = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] in_rd = '0;
    logic [31:0] in_data = '0;
    logic wr_hold = 1'b0;
    logic flush = 1'b0;
    logic Ld;
    logic [3:0] decode_input;
    logic [31:0] Ds;
    logic [3:0] S1 = '0, S2 = '0, S3 = '0;
    logic hit1, hit2, hit3;
    logic [31:0] fwd1, fwd2, fwd3;
    logic [2:0] count;
    logic err_r15;
    int n_chk = 0;
    int n_fail = 0;
    logic [35:0] exp_q [$];
`ifdef REG_WBQ_FWD_EN
    localparam logic [31:0] FWD_B = 32'hB;
`else
    localparam logic [31:0] FWD_B = 32'h0;
`endif

    reg_writeback_queue dut (
        .clock(clock), .R(R), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wr_hold(wr_hold), .flush(flush),
        .Ld(Ld), .decode_input(decode_input), .Ds(Ds),
        .S1(S1), .S2(S2), .S3(S3), .hit1(hit1), .hit2(hit2), .hit3(hit3),
        .fwd1(fwd1), .fwd2(fwd2), .fwd3(fwd3), .count(count), .err_r15(err_r15)
    );

    always #5 clock = ~clock;

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] rd, input logic [31:0] d, input bit take);
        in_valid = 1'b1;
        in_rd = rd;
        in_data = d;
        if (take) exp_q.push_back({rd, d});
        tick();
        in_valid = 1'b0;
    endtask

    // monitor: every regfile write must be the oldest expected write
    always @(negedge clock) begin
        if (Ld) begin
            if (exp_q.size() == 0) check("unexpected_write", {decode_input, Ds}, 36'h0);
            else check("write_port", {decode_input, Ds}, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_ld", Ld, 0);
        check("rst_err", err_r15, 0);
        check("rst_hit1", hit1, 0);
        check("rst_fwd1", fwd1, 0);
        #1 R = 1'b1;
        tick();
        // 1: single write, one-cycle latency
        push(4'd3, 32'h11111111, 1);
        check("t1_ld", Ld, 1);
        check("t1_addr", decode_input, 3);
        check("t1_data", Ds, 32'h11111111);
        tick();
        check("t1_ld_after", Ld, 0);
        check("t1_count_after", count, 0);
        // 2: fill under hold, overflow refused, drain in order
        wr_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'(i), 32'h100 + 32'(i), 1);
        check("t2_count_full", count, 4);
        check("t2_ready_full", in_ready, 0);
        push(4'd5, 32'h105, 0);
        check("t2_count_no_push", count, 4);
        wr_hold = 1'b0;
        repeat (4) tick();
        check("t2_count_drained", count, 0);
        check("t2_all_written", exp_q.size(), 0);
        // 3: hits and youngest forwarding
        wr_hold = 1'b1;
        push(4'd5, 32'hA, 1);
        push(4'd5, 32'hB, 1);
        S1 = 4'd5;
        S2 = 4'd6;
        #1;
        check("t3_hit1", hit1, 1);
        check("t3_fwd1", fwd1, FWD_B);
        check("t3_hit2", hit2, 0);
        check("t3_fwd2", fwd2, 0);
        wr_hold = 1'b0;
        tick();
        tick();
        check("t3_count_drained", count, 0);
        check("t3_hit1_empty", hit1, 0);
        // 4: R15 write dropped, sticky error
        push(4'hF, 32'hDEAD, 0);
        check("t4_count", count, 0);
        check("t4_err", err_r15, 1);
        S3 = 4'hF;
        #1;
        check("t4_hit3", hit3, 0);
        repeat (3) tick();
        check("t4_err_sticky", err_r15, 1);
        // 5: flush beats a same-cycle push
        wr_hold = 1'b1;
        push(4'd7, 32'h7, 1);
        push(4'd8, 32'h8, 1);
        push(4'd9, 32'h9, 1);
        wr_hold = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1;
        in_rd = 4'd10;
        in_data = 32'h10;
        #1;
        check("t5_ld_flush", Ld, 0);
        exp_q.delete();
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t5_count", count, 0);
        S1 = 4'd10;
        #1;
        check("t5_pushed_absent", hit1, 0);
        repeat (2) tick();
        // 6: asynchronous reset mid-drain
        wr_hold = 1'b1;
        push(4'd1, 32'h21, 1);
        push(4'd2, 32'h22, 1);
        push(4'd3, 32'h23, 1);
        wr_hold = 1'b0;
        #1;
        check("t6_ld_before", Ld, 1);
        #1 R = 1'b0;
        exp_q.delete();
        #1;
        check("t6_ld_rst", Ld, 0);
        check("t6_count_rst", count, 0);
        check("t6_ready_rst", in_ready, 1);
        check("t6_err_rst", err_r15, 0);
        #2 R = 1'b1;
        push(4'd2, 32'h2222, 1);
        check("t6_ld_after", Ld, 1);
        check("t6_addr_after", decode_input, 2);
        tick();
        check("t6_count_end", count, 0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
